// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: walks a 2-input gate through all four input vectors, samples the output
// after a settle time and scores it against TRUTH_TABLE. Rev 1.0.
`default_nettype none

module gate_sweep_ctrl #(
  parameter logic [3:0] TRUTH_TABLE   = 4'b0001,
  parameter int         SETTLE_CYCLES = 2,
  parameter int         NUM_SWEEPS    = 1,
  parameter int         ERR_CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 gate_in1_o,
  output logic                 gate_in2_o,
  input  logic                 gate_out1_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [3:0]           err_mask_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);

  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam int SW_W = $clog2(NUM_SWEEPS + 1);
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [SW_W-1:0] SWEEP_LAST  = SW_W'(NUM_SWEEPS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  if (SETTLE_CYCLES < 1 || NUM_SWEEPS < 1 || ERR_CNT_W < 2) begin : g_bad_param
    $error("gate_sweep_ctrl: illegal parameter value");
  end

  logic [1:0]           state_q, state_d;
  logic [1:0]           vec_q, vec_d;
  logic [SW_W-1:0]      sweep_q, sweep_d;
  logic [SC_W-1:0]      settle_q, settle_d;
  logic [3:0]           mask_q, mask_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic                 pass_q, pass_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 in1_q, in1_d;
  logic                 in2_q, in2_d;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    sweep_d  = sweep_q;
    settle_d = settle_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d  = S_SETTLE;
          vec_d    = 2'd0;
          sweep_d  = '0;
          settle_d = '0;
          mask_d   = 4'd0;
          cnt_d    = '0;
          pass_d   = 1'b0;
        end
      end
      S_SETTLE: begin
        if (abort_i) begin
          state_d  = S_IDLE;
          settle_d = '0;
          pass_d   = 1'b0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d  = S_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (abort_i) begin
          state_d = S_IDLE;
          pass_d  = 1'b0;
        end else begin
          if (gate_out1_i != TRUTH_TABLE[vec_q]) begin
            mask_d[vec_q] = 1'b1;
            if (cnt_q != {ERR_CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
          end
          if (vec_q != 2'd3) begin
            vec_d   = vec_q + 2'd1;
            state_d = S_SETTLE;
          end else if (sweep_q != SWEEP_LAST) begin
            vec_d   = 2'd0;
            sweep_d = sweep_q + 1'b1;
            state_d = S_SETTLE;
          end else begin
            // pass must see this cycle's mask update, hence mask_d
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (mask_d == 4'd0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    in1_d  = busy_d & vec_d[1];
    in2_d  = busy_d & vec_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= 2'd0;
      sweep_q  <= '0;
      settle_q <= '0;
      mask_q   <= 4'd0;
      cnt_q    <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      in1_q    <= 1'b0;
      in2_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      sweep_q  <= sweep_d;
      settle_q <= settle_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
    end
  end

  assign gate_in1_o  = in1_q;
  assign gate_in2_o  = in2_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_mask_o  = mask_q;
  assign err_count_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: drives two controller instances against NOR gate models with
// injectable per-vector faults and scores them against an arithmetic reference model.
`default_nettype none

module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
  logic [3:0] flip_a = 4'd0, flip_b = 4'd0;
  logic in1_a, in2_a, out_a, busy_a, done_a, pass_a;
  logic in1_b, in2_b, out_b, busy_b, done_b, pass_b;
  logic [3:0] mask_a, mask_b, cnt_a;
  logic [1:0] cnt_b;
  int sel = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Gate under test: NOR with the output inverted on any vector whose flip bit is set
  assign out_a = ~(in1_a | in2_a) ^ flip_a[{in1_a, in2_a}];
  assign out_b = ~(in1_b | in2_b) ^ flip_b[{in1_b, in2_b}];

  gate_sweep_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a),
    .gate_in1_o(in1_a), .gate_in2_o(in2_a), .gate_out1_i(out_a),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a),
    .err_mask_o(mask_a), .err_count_o(cnt_a)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(2), .NUM_SWEEPS(2), .ERR_CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b),
    .gate_in1_o(in1_b), .gate_in2_o(in2_b), .gate_out1_i(out_b),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b),
    .err_mask_o(mask_b), .err_count_o(cnt_b)
  );

  logic       c_busy, c_done, c_pass;
  logic [1:0] c_vec;
  logic [3:0] c_mask, c_cnt;
  always_comb begin
    c_busy = (sel != 0) ? busy_b : busy_a;
    c_done = (sel != 0) ? done_b : done_a;
    c_pass = (sel != 0) ? pass_b : pass_a;
    c_vec  = (sel != 0) ? {in1_b, in2_b} : {in1_a, in2_a};
    c_mask = (sel != 0) ? mask_b : mask_a;
    c_cnt  = (sel != 0) ? {2'b00, cnt_b} : cnt_a;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input int s, input logic v);
    if (s != 0) start_b = v; else start_a = v;
  endtask

  // One complete run; reference: vector k of each sweep is held SETTLE+1 = 3 cycles,
  // errors = faulty vectors * sweeps (saturated), done after 4*sweeps*3 edges.
  task automatic run(input int s, input logic [3:0] flip, input bit hold);
    int n_sw, lim, len, edges, exp_cnt;
    sel   = s;
    n_sw  = (s != 0) ? 2 : 1;
    lim   = (s != 0) ? 3 : 15;
    len   = 4 * n_sw * 3;
    if (s != 0) flip_b = flip; else flip_a = flip;
    @(negedge clk);
    set_start(s, 1'b1);
    @(posedge clk); #1;
    if (!hold) set_start(s, 1'b0);
    edges = 0;
    while (c_done !== 1'b1 && edges < len + 10) begin
      if (edges < len) begin
        chk("vector", 32'(c_vec), 32'((edges / 3) % 4));
        chk("busy", 32'(c_busy), 32'd1);
      end
      @(posedge clk); #1;
      edges++;
    end
    set_start(s, 1'b0);
    exp_cnt = $countones(flip) * n_sw;
    if (exp_cnt > lim) exp_cnt = lim;
    chk("latency", edges, len);
    chk("done", 32'(c_done), 32'd1);
    chk("err_mask", 32'(c_mask), 32'(flip));
    chk("err_count", 32'(c_cnt), exp_cnt);
    chk("pass", 32'(c_pass), 32'(flip == 4'd0));
    @(posedge clk); #1;
    chk("done_pulse", 32'(c_done), 32'd0);
    chk("pass_hold", 32'(c_pass), 32'(flip == 4'd0));
    chk("idle_vec", 32'(c_vec), 32'd0);
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_outs", {27'd0, done_a, pass_a, in1_a, in2_a, 1'b0}, 32'd0);
    chk("rst_mask_cnt", {24'd0, mask_a, cnt_a}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 4'b0000, 1'b0);   // good NOR
    run(0, 4'b0001, 1'b0);   // stuck-at-0
    run(0, 4'b1111, 1'b0);   // OR gate
    run(1, 4'b1111, 1'b0);   // OR gate, 2-bit saturating count
    run(1, 4'b1110, 1'b0);   // stuck-at-1, two sweeps
    run(0, 4'b0000, 1'b1);   // start held high through the run
    for (int i = 0; i < 8; i++) run(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);

    // abort during the third SETTLE: partial results kept, no done
    sel = 0; flip_a = 4'b0011;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (7) @(posedge clk);
    #1; chk("pre_abort_vec", 32'({in1_a, in2_a}), 32'd2);
    abort_a = 1'b1;
    @(posedge clk); #1; abort_a = 1'b0;
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_vec", 32'({in1_a, in2_a}), 32'd0);
    chk("abort_mask", 32'(mask_a), 32'h3);
    chk("abort_cnt", 32'(cnt_a), 32'd2);
    chk("abort_pass", 32'(pass_a), 32'd0);
    seen = 0;
    repeat (15) begin @(posedge clk); #1; if (done_a) seen++; end
    chk("abort_no_done", seen, 0);

    // abort wins over start in IDLE
    @(negedge clk); start_a = 1'b1; abort_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0; abort_a = 1'b0;
    chk("abort_start_idle", 32'(busy_a), 32'd0);

    // async reset during the second SAMPLE
    flip_a = 4'b0001;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {27'd0, busy_a, done_a, pass_a, in1_a, in2_a}, 32'd0);
    chk("mid_rst_mask_cnt", {24'd0, mask_a, cnt_a}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run(0, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
